// File: rtl/mem_refill_arbiter_if.sv
// Bundle of ICache, DCache and main-memory signals around the refill arbiter.
// master: the arbiter itself. slave: the caches and the memory it serves.
interface mem_refill_arbiter_if #(
   parameter int unsigned BEAT_W = 2
);
   // ICache refill path
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic [BEAT_W-1:0] i_beat;
   logic              i_done;
   // DCache refill/writeback path
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic [BEAT_W-1:0] d_beat;
   logic              d_done;
   // Main-memory line-burst port
   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_we;
   logic [31:0]       mem_cmd_addr;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_wvalid;
   logic [31:0]       mem_wdata;
   logic              mem_wready;

   modport master (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata, i_beat, i_done,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_beat, d_done,
      output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wvalid, mem_wdata,
      input  mem_cmd_ready, mem_rvalid, mem_rdata, mem_wready
   );

   modport slave (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata, i_beat, i_done,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_beat, d_done,
      input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wvalid, mem_wdata,
      output mem_cmd_ready, mem_rvalid, mem_rdata, mem_wready
   );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Shares one line-burst memory port between ICache refills and DCache
// refills/writebacks. One line command per burst, read beats steered
// combinationally to the owner, one-cycle done pulse at burst end.
module mem_refill_arbiter #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned BEAT_W     = 2
) (
   input logic                  clk,
   input logic                  rst,
   mem_refill_arbiter_if.master bus
);

   localparam logic [31:0]       AlignMask = ~((32'(LINE_WORDS) << 2) - 32'd1);
   localparam logic [BEAT_W-1:0] LastBeat  = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {StIdle, StCmd, StRd, StWr, StDone} state_e;
   typedef enum logic {OwnI, OwnD} owner_e;

   state_e            stateQ;
   owner_e            ownerQ;
   owner_e            lastServedQ;
   owner_e            winner;
   logic [BEAT_W-1:0] beatQ;
   logic [31:0]       addrQ;
   logic              weQ;
   logic              iGntQ;
   logic              dGntQ;
   logic              iDoneQ;
   logic              dDoneQ;
   logic              cmdValidQ;
   logic              wValidQ;
   logic              inData;
   logic              iRvalid;
   logic              dRvalid;

   // Pick the next owner; on a tie the requester not served last wins.
   always_comb begin
      winner = OwnI;
      if (bus.i_req && bus.d_req) begin
         winner = (lastServedQ == OwnI) ? OwnD : OwnI;
      end else if (bus.d_req) begin
         winner = OwnD;
      end
   end

   // Burst sequencer with registered grant, command, write-valid and done outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ      <= StIdle;
         ownerQ      <= OwnI;
         lastServedQ <= OwnI;
         beatQ       <= '0;
         addrQ       <= '0;
         weQ         <= 1'b0;
         iGntQ       <= 1'b0;
         dGntQ       <= 1'b0;
         iDoneQ      <= 1'b0;
         dDoneQ      <= 1'b0;
         cmdValidQ   <= 1'b0;
         wValidQ     <= 1'b0;
      end else begin
         iDoneQ <= 1'b0;
         dDoneQ <= 1'b0;
         unique case (stateQ)
            StIdle: begin
               if (bus.i_req || bus.d_req) begin
                  ownerQ    <= winner;
                  addrQ     <= ((winner == OwnD) ? bus.d_addr : bus.i_addr) & AlignMask;
                  // ICache requests are always reads
                  weQ       <= (winner == OwnD) && bus.d_we;
                  iGntQ     <= (winner == OwnI);
                  dGntQ     <= (winner == OwnD);
                  cmdValidQ <= 1'b1;
                  stateQ    <= StCmd;
               end
            end
            StCmd: begin
               if (bus.mem_cmd_ready) begin
                  cmdValidQ <= 1'b0;
                  beatQ     <= '0;
                  if (weQ) begin
                     wValidQ <= 1'b1;
                     stateQ  <= StWr;
                  end else begin
                     stateQ  <= StRd;
                  end
               end
            end
            StRd: begin
               if (bus.mem_rvalid) begin
                  beatQ <= beatQ + BEAT_W'(1);
                  if (beatQ == LastBeat) begin
                     iDoneQ <= (ownerQ == OwnI);
                     dDoneQ <= (ownerQ == OwnD);
                     stateQ <= StDone;
                  end
               end
            end
            StWr: begin
               if (bus.mem_wready) begin
                  beatQ <= beatQ + BEAT_W'(1);
                  if (beatQ == LastBeat) begin
                     wValidQ <= 1'b0;
                     dDoneQ  <= 1'b1;
                     stateQ  <= StDone;
                  end
               end
            end
            StDone: begin
               iGntQ       <= 1'b0;
               dGntQ       <= 1'b0;
               lastServedQ <= ownerQ;
               stateQ      <= StIdle;
            end
            default: stateQ <= StIdle;
         endcase
      end
   end

   // Steer read beats and beat index to the owner only; memory beats outside RD are dropped.
   always_comb begin
      inData  = (stateQ == StRd) || (stateQ == StWr);
      iRvalid = (stateQ == StRd) && (ownerQ == OwnI) && bus.mem_rvalid;
      dRvalid = (stateQ == StRd) && (ownerQ == OwnD) && bus.mem_rvalid;
   end

   assign bus.i_gnt         = iGntQ;
   assign bus.d_gnt         = dGntQ;
   assign bus.i_done        = iDoneQ;
   assign bus.d_done        = dDoneQ;
   assign bus.i_rvalid      = iRvalid;
   assign bus.d_rvalid      = dRvalid;
   assign bus.i_rdata       = iRvalid ? bus.mem_rdata : '0;
   assign bus.d_rdata       = dRvalid ? bus.mem_rdata : '0;
   assign bus.i_beat        = (inData && (ownerQ == OwnI)) ? beatQ : '0;
   assign bus.d_beat        = (inData && (ownerQ == OwnD)) ? beatQ : '0;
   assign bus.mem_cmd_valid = cmdValidQ;
   assign bus.mem_cmd_we    = cmdValidQ & weQ;
   assign bus.mem_cmd_addr  = cmdValidQ ? addrQ : '0;
   assign bus.mem_wvalid    = wValidQ;
   assign bus.mem_wdata     = wValidQ ? bus.d_wdata : '0;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomized bench for mem_refill_arbiter: the bench plays both caches and the
// memory, and predicts each burst from the arbitration and burst rules.
module tb_mem_refill_arbiter;

   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned BEAT_W     = 2;
   localparam logic [31:0] alignMask  = ~32'h0000_000F;

   logic clk = 1'b0;
   logic rst;

   int   nChecks = 0;
   int   nFails  = 0;
   bit   lastD;          // model: last served requester was DCache
   logic [31:0] rdPat[$];
   bit   wrPat[$];

   always #5 clk = ~clk;

   mem_refill_arbiter_if #(.BEAT_W(BEAT_W)) bus ();

   mem_refill_arbiter #(
      .LINE_WORDS(LINE_WORDS),
      .BEAT_W    (BEAT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkEq({tag, "_i_gnt"}, bus.i_gnt, 0);
      checkEq({tag, "_i_rvalid"}, bus.i_rvalid, 0);
      checkEq({tag, "_i_rdata"}, bus.i_rdata, 0);
      checkEq({tag, "_i_beat"}, bus.i_beat, 0);
      checkEq({tag, "_i_done"}, bus.i_done, 0);
      checkEq({tag, "_d_gnt"}, bus.d_gnt, 0);
      checkEq({tag, "_d_rvalid"}, bus.d_rvalid, 0);
      checkEq({tag, "_d_rdata"}, bus.d_rdata, 0);
      checkEq({tag, "_d_beat"}, bus.d_beat, 0);
      checkEq({tag, "_d_done"}, bus.d_done, 0);
      checkEq({tag, "_cmd_valid"}, bus.mem_cmd_valid, 0);
      checkEq({tag, "_cmd_we"}, bus.mem_cmd_we, 0);
      checkEq({tag, "_cmd_addr"}, bus.mem_cmd_addr, 0);
      checkEq({tag, "_wvalid"}, bus.mem_wvalid, 0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
      bus.d_wdata = 0; bus.mem_cmd_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
      bus.mem_wready = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lastD = 1'b0;
   endtask

   // A new request from the requester that is not being served must wait.
   task automatic raiseOther(input bit ownD);
      if (ownD && !bus.i_req) begin
         bus.i_req = 1; bus.i_addr = $urandom;
      end else if (!ownD && !bus.d_req) begin
         bus.d_req = 1; bus.d_addr = $urandom; bus.d_we = 1'($urandom);
      end
   endtask

   // Entered at a negedge with the DUT idle and requests already driven.
   // Predicts the owner, then runs IDLE, CMD, the data beats and DONE.
   task automatic doBurst(input int cmdStall, input bit gaps, input bit spurious,
                          input bit dropAt1, input bit keepReq);
      bit          ownD;
      bit          expWe;
      logic [31:0] expAddr;
      logic [31:0] data;
      logic [31:0] lineW [4];
      int          acc;
      int          cyc;
      int          g;
      ownD    = bus.d_req && (!bus.i_req || !lastD);
      expAddr = (ownD ? bus.d_addr : bus.i_addr) & alignMask;
      expWe   = ownD && bus.d_we;
      for (int k = 0; k < 4; k++) lineW[k] = $urandom;
      // idle cycle in which the request is sampled
      bus.mem_rvalid = spurious; bus.mem_rdata = $urandom;
      bus.mem_cmd_ready = 1'($urandom); bus.mem_wready = 0;
      #1;
      checkEq("idle_cmd_valid", bus.mem_cmd_valid, 0);
      checkEq("idle_gnt", {bus.i_gnt, bus.d_gnt}, 0);
      checkEq("idle_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
      checkEq("idle_done", {bus.i_done, bus.d_done}, 0);
      @(negedge clk);
      // command phase, optionally stalled
      for (int s = 0; s <= cmdStall; s++) begin
         bus.mem_cmd_ready = (s == cmdStall);
         bus.mem_rvalid = spurious && 1'($urandom);
         bus.mem_rdata = $urandom;
         #1;
         checkEq("cmd_valid", bus.mem_cmd_valid, 1);
         checkEq("cmd_addr", bus.mem_cmd_addr, expAddr);
         checkEq("cmd_we", bus.mem_cmd_we, expWe);
         checkEq("cmd_gnt", {bus.i_gnt, bus.d_gnt}, {!ownD, ownD});
         checkEq("cmd_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
         checkEq("cmd_beat", {bus.i_beat, bus.d_beat}, 0);
         checkEq("cmd_wvalid", bus.mem_wvalid, 0);
         @(negedge clk);
      end
      bus.mem_cmd_ready = 0; bus.mem_rvalid = 0;
      if (!expWe) begin
         for (int k = 0; k < 4; k++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            for (int j = 0; j < g; j++) begin
               bus.mem_rvalid = 0;
               #1;
               checkEq("gap_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
               checkEq("gap_beat", ownD ? bus.d_beat : bus.i_beat, k);
               checkEq("gap_done", {bus.i_done, bus.d_done}, 0);
               @(negedge clk);
            end
            data = (rdPat.size() > 0) ? rdPat.pop_front() : $urandom;
            bus.mem_rvalid = 1; bus.mem_rdata = data;
            if (dropAt1 && k == 1) begin
               if (ownD) bus.d_req = 0; else bus.i_req = 0;
            end
            if (k == 2 && $urandom_range(0, 2) == 0) raiseOther(ownD);
            #1;
            checkEq("rd_i_rvalid", bus.i_rvalid, !ownD);
            checkEq("rd_d_rvalid", bus.d_rvalid, ownD);
            checkEq("rd_i_rdata", bus.i_rdata, ownD ? 32'd0 : data);
            checkEq("rd_d_rdata", bus.d_rdata, ownD ? data : 32'd0);
            checkEq("rd_beat", ownD ? bus.d_beat : bus.i_beat, k);
            checkEq("rd_other_beat", ownD ? bus.i_beat : bus.d_beat, 0);
            checkEq("rd_gnt", {bus.i_gnt, bus.d_gnt}, {!ownD, ownD});
            checkEq("rd_done", {bus.i_done, bus.d_done}, 0);
            @(negedge clk);
         end
         bus.mem_rvalid = 0;
      end else begin
         acc = 0;
         cyc = 0;
         while (acc < 4) begin
            bus.d_wdata = lineW[acc];
            if (wrPat.size() > 0) bus.mem_wready = wrPat.pop_front();
            else bus.mem_wready = (cyc > 20) || ($urandom_range(0, 2) != 0);
            if (acc == 2 && $urandom_range(0, 2) == 0) raiseOther(1'b1);
            #1;
            checkEq("wr_wvalid", bus.mem_wvalid, 1);
            checkEq("wr_wdata", bus.mem_wdata, lineW[acc]);
            checkEq("wr_d_beat", bus.d_beat, acc);
            checkEq("wr_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
            checkEq("wr_gnt", {bus.i_gnt, bus.d_gnt}, 2'b01);
            checkEq("wr_done", {bus.i_done, bus.d_done}, 0);
            if (bus.mem_wready) acc++;
            cyc++;
            @(negedge clk);
         end
         bus.mem_wready = 0;
      end
      // done cycle: requester drops here unless it wants another line
      if (!keepReq) begin
         if (ownD) bus.d_req = 0; else bus.i_req = 0;
      end
      #1;
      checkEq("done_i", bus.i_done, !ownD);
      checkEq("done_d", bus.d_done, ownD);
      checkEq("done_wvalid", bus.mem_wvalid, 0);
      checkEq("done_cmd_valid", bus.mem_cmd_valid, 0);
      checkEq("done_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
      lastD = ownD;
      @(negedge clk);
   endtask

   task automatic resetMidBurst();
      bus.i_req = 1; bus.d_req = 0; bus.i_addr = $urandom;
      bus.mem_cmd_ready = 1; bus.mem_rvalid = 0;
      @(negedge clk);
      @(negedge clk);
      bus.mem_cmd_ready = 0;
      for (int k = 0; k < 2; k++) begin
         bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
         @(negedge clk);
      end
      #1;
      checkEq("rst_pre_beat", bus.i_beat, 2);
      rst = 1; bus.i_req = 0;
      @(negedge clk);
      rst = 0;
      #1;
      checkAllZero("rst_mid");
      lastD = 1'b0;
      bus.mem_rvalid = 0;
      repeat (3) begin
         #1;
         checkEq("rst_no_done", {bus.i_done, bus.i_gnt}, 0);
         @(negedge clk);
      end
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = $urandom;
      doBurst(0, 1, 0, 0, 0);
   endtask

   initial begin
      int r;
      doReset();
      #1;
      checkAllZero("reset");
      @(negedge clk);

      // single ICache refill, back-to-back beats
      bus.i_req = 1; bus.i_addr = 32'h1234;
      rdPat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      doBurst(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);

      // tie after reset goes to D; D re-requests, second tie goes to I
      doReset();
      bus.i_req = 1; bus.i_addr = 32'h0000_4000;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_8008;
      doBurst(0, 0, 0, 0, 1);
      doBurst(0, 0, 0, 0, 0);
      doBurst(0, 0, 0, 0, 0);

      // DCache writeback with stalling write ready
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80;
      wrPat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      doBurst(0, 0, 0, 0, 0);

      // command held off for five cycles
      bus.i_req = 1; bus.i_addr = 32'hDEAD_BEEF;
      doBurst(5, 0, 0, 0, 0);

      resetMidBurst();

      // spurious memory beats outside RD, requester drops early
      bus.i_req = 1; bus.i_addr = 32'h0000_1F0C;
      doBurst(1, 1, 1, 1, 0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         if (!bus.i_req && !bus.d_req) begin
            r = $urandom_range(1, 3);
            if (r[0]) begin bus.i_req = 1; bus.i_addr = $urandom; end
            if (r[1]) begin bus.d_req = 1; bus.d_addr = $urandom; bus.d_we = 1'($urandom); end
         end else if ($urandom_range(0, 2) == 0) begin
            raiseOther(bus.d_req);
         end
         doBurst($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
